rv32_branch_predictor: RTL and testbench

RV32_BRANCH_PREDICTOR -- requirements
Module: rv32_branch_predictor

---
 rtl/rv32_bp_pkg.sv | 31 +++
 rtl/rv32_bp_counter.sv | 22 ++
 rtl/rv32_branch_predictor.sv | 154 +++++++++++++++
 tb/tb_rv32_branch_predictor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_bp_pkg.sv
// Shared definitions for the RV32 branch predictor: counter encodings,
// the BTB entry view and helpers that derive index/tag widths.
package rv32_bp_pkg;

  // 2-bit saturating direction counter states
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Widest datapath the entry view is sized for; narrower designs zero-extend
  localparam int BP_MAX_XLEN = 64;

  typedef struct packed {
    logic                   valid;
    logic                   jump;
    logic [BP_MAX_XLEN-1:0] tag;
    logic [BP_MAX_XLEN-1:0] target;
  } btb_entry_t;

  // Number of PC bits used to select a table entry
  function automatic int bp_idx_width(input int entries);
    return $clog2(entries);
  endfunction

  // Remaining upper PC bits kept as the tag (word-aligned PCs drop bits 1:0)
  function automatic int bp_tag_width(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/rv32_bp_counter.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module rv32_bp_counter
  import rv32_bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Step toward strongly-taken or strongly-not-taken, holding at the ends
  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
      default: ctr_next = CTR_WNT;
    endcase
  end

endmodule

// File: rtl/rv32_branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters. Fetch looks up
// combinationally; execute resolves, trains the table and raises a
// registered redirect on mispredict. Also keeps saturating perf counters.
module rv32_branch_predictor
  import rv32_bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  f_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             e_valid,
  input  logic [XLEN-1:0]  e_pc,
  input  logic             e_is_branch,
  input  logic             e_is_jump,
  input  logic             e_taken,
  input  logic [XLEN-1:0]  e_target,
  input  logic             e_pred_taken,
  input  logic [XLEN-1:0]  e_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_ctl,
  output logic [CNT_W-1:0] stat_mis
);

  localparam int IDX_W = bp_idx_width(ENTRIES);
  localparam int TAG_W = bp_tag_width(XLEN, ENTRIES);

  // Control state is reset; tag/target payload is not
  logic             valid_q  [ENTRIES];
  logic             jump_q   [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[XLEN-1:IDX_W+2];
  assign e_idx = e_pc[IDX_W+1:2];
  assign e_tag = e_pc[XLEN-1:IDX_W+2];

  btb_entry_t rd_entry;
  logic       f_hit;
  logic       bp_unused;

  // Assemble the entry selected by the fetch PC and form the prediction
  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[f_idx];
    rd_entry.jump   = jump_q[f_idx];
    rd_entry.tag    = BP_MAX_XLEN'(tag_q[f_idx]);
    rd_entry.target = BP_MAX_XLEN'(target_q[f_idx]);
    f_hit           = rd_entry.valid & (rd_entry.tag == BP_MAX_XLEN'(f_tag));
    pred_taken      = f_hit & (rd_entry.jump | ctr_q[f_idx][1]);
    pred_target     = pred_taken ? rd_entry.target[XLEN-1:0] : f_pc + XLEN'(4);
  end

  assign bp_unused = &{1'b0, rd_entry.target, f_pc[1:0], e_pc[1:0]};

  logic            is_cf;
  logic            is_jump;
  logic            taken;
  logic            e_hit;
  logic [XLEN-1:0] correct_pc;
  logic            mis_now;
  logic            tbl_write;
  logic            tbl_inval;
  logic [1:0]      ctr_step;
  logic [1:0]      ctr_new;

  rv32_bp_counter u_counter (
    .ctr      (ctr_q[e_idx]),
    .taken    (e_taken),
    .ctr_next (ctr_step)
  );

  // Resolve the executed instruction: true outcome, mispredict and table action
  always_comb begin
    is_cf      = e_is_branch | e_is_jump;
    is_jump    = e_is_jump;
    taken      = is_cf & e_taken;
    e_hit      = valid_q[e_idx] & (tag_q[e_idx] == e_tag);
    correct_pc = taken ? e_target : e_pc + XLEN'(4);
    mis_now    = e_valid & ((e_pred_taken != taken) |
                            (taken & (e_pred_target != e_target)));
    tbl_write  = e_valid & is_cf;
    tbl_inval  = e_valid & ~is_cf & e_pred_taken & e_hit;
    if (is_jump)
      ctr_new = CTR_ST;
    else if (e_hit)
      ctr_new = ctr_step;
    else
      ctr_new = e_taken ? CTR_WT : CTR_WNT;
  end

  // Valid/jump/counter state: trained on resolved control flow, dropped when stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        jump_q[i]  <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (tbl_write) begin
      valid_q[e_idx] <= 1'b1;
      jump_q[e_idx]  <= is_jump;
      ctr_q[e_idx]   <= ctr_new;
    end else if (tbl_inval) begin
      valid_q[e_idx] <= 1'b0;
    end
  end

  // Tag and target payload; meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (tbl_write) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= e_target;
    end
  end

  // Registered redirect: one-cycle mispredict pulse, PC held between resolutions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mis_now;
      if (e_valid)
        redirect_pc <= correct_pc;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ctl <= '0;
      stat_mis <= '0;
    end else begin
      if (tbl_write && (stat_ctl != '1))
        stat_ctl <= stat_ctl + CNT_W'(1);
      if (mis_now && (stat_mis != '1))
        stat_mis <= stat_mis + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Directed bench for rv32_branch_predictor with hand-computed expectations.
module tb_rv32_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [XLEN-1:0]  f_pc = '0;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             e_valid = 1'b0;
  logic [XLEN-1:0]  e_pc = '0;
  logic             e_is_branch = 1'b0;
  logic             e_is_jump = 1'b0;
  logic             e_taken = 1'b0;
  logic [XLEN-1:0]  e_target = '0;
  logic             e_pred_taken = 1'b0;
  logic [XLEN-1:0]  e_pred_target = '0;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stat_ctl;
  logic [CNT_W-1:0] stat_mis;

  int vectorCount = 0;
  int missCount   = 0;
  int expCtl      = 0;
  int expMis      = 0;

  rv32_branch_predictor #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .f_pc          (f_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .e_valid       (e_valid),
    .e_pc          (e_pc),
    .e_is_branch   (e_is_branch),
    .e_is_jump     (e_is_jump),
    .e_taken       (e_taken),
    .e_target      (e_target),
    .e_pred_taken  (e_pred_taken),
    .e_pred_target (e_pred_target),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .stat_ctl      (stat_ctl),
    .stat_mis      (stat_mis)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPredict(input logic [31:0] pc, input logic expTaken,
                              input logic [31:0] expTarget);
    f_pc = pc;
    #1;
    checkOutput("pred_taken", 32'(pred_taken), 32'(expTaken));
    checkOutput("pred_target", pred_target, expTarget);
  endtask

  task automatic applyStimulus(input logic br, input logic jmp, input logic tk,
                               input logic [31:0] pc, input logic [31:0] tgt,
                               input logic ptk, input logic [31:0] ptgt,
                               input logic expMisp, input logic [31:0] expRedir);
    @(negedge clk);
    e_valid       = 1'b1;
    e_is_branch   = br;
    e_is_jump     = jmp;
    e_taken       = tk;
    e_pc          = pc;
    e_target      = tgt;
    e_pred_taken  = ptk;
    e_pred_target = ptgt;
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    if ((br || jmp) && expCtl < CNT_MAX) expCtl++;
    if (expMisp && expMis < CNT_MAX) expMis++;
    checkOutput("mispredict", 32'(mispredict), 32'(expMisp));
    checkOutput("redirect_pc", redirect_pc, expRedir);
    checkOutput("stat_ctl", 32'(stat_ctl), 32'(expCtl));
    checkOutput("stat_mis", 32'(stat_mis), 32'(expMis));
  endtask

  initial begin
    // Power-on reset
    #1;
    checkOutput("rst_mispredict", 32'(mispredict), 32'd0);
    checkOutput("rst_redirect", redirect_pc, 32'd0);
    checkOutput("rst_stat_ctl", 32'(stat_ctl), 32'd0);
    checkOutput("rst_stat_mis", 32'(stat_mis), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Cold miss
    checkPredict(32'h100, 1'b0, 32'h104);

    // Training taken twice, then not-taken three times, then one taken
    applyStimulus(1, 0, 1, 32'h100, 32'h80, 0, 32'h0,  1, 32'h80);
    checkPredict(32'h100, 1'b1, 32'h80);
    applyStimulus(1, 0, 1, 32'h100, 32'h80, 1, 32'h80, 0, 32'h80);
    checkPredict(32'h100, 1'b1, 32'h80);
    applyStimulus(1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 1, 32'h104);
    checkPredict(32'h100, 1'b1, 32'h80);
    applyStimulus(1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 1, 32'h104);
    checkPredict(32'h100, 1'b0, 32'h104);
    applyStimulus(1, 0, 0, 32'h100, 32'h80, 0, 32'h0,  0, 32'h104);
    checkPredict(32'h100, 1'b0, 32'h104);
    applyStimulus(1, 0, 1, 32'h100, 32'h80, 0, 32'h0,  1, 32'h80);
    checkPredict(32'h100, 1'b0, 32'h104);

    // Direction mispredict, then the pulse drops and the PC holds
    applyStimulus(1, 0, 1, 32'h200, 32'h240, 0, 32'h0, 1, 32'h240);
    @(posedge clk);
    #1;
    checkOutput("mis_pulse_end", 32'(mispredict), 32'd0);
    checkOutput("redirect_hold", redirect_pc, 32'h240);

    // Target mispredict, then a correct prediction
    applyStimulus(1, 0, 1, 32'h300, 32'h340, 1, 32'h380, 1, 32'h340);
    applyStimulus(1, 0, 1, 32'h300, 32'h340, 1, 32'h340, 0, 32'h340);

    // Aliasing: jump at 0x40 replaced by a branch at the same index
    applyStimulus(0, 1, 1, 32'h40, 32'h400, 0, 32'h0, 1, 32'h400);
    checkPredict(32'h40, 1'b1, 32'h400);
    applyStimulus(1, 0, 1, 32'h40 + 4 * ENTRIES, 32'h500, 0, 32'h0, 1, 32'h500);
    checkPredict(32'h40, 1'b0, 32'h44);
    checkPredict(32'h40 + 4 * ENTRIES, 1'b1, 32'h500);

    // Stale entry: predicted taken but not control flow
    applyStimulus(0, 1, 1, 32'h40, 32'h400, 0, 32'h0, 1, 32'h400);
    checkPredict(32'h40, 1'b1, 32'h400);
    applyStimulus(0, 0, 0, 32'h40, 32'h0, 1, 32'h400, 1, 32'h44);
    checkPredict(32'h40, 1'b0, 32'h44);

    // Both flags high behaves as a jump (counter strongly taken)
    applyStimulus(1, 1, 1, 32'h20, 32'h60, 0, 32'h0,  1, 32'h60);
    applyStimulus(1, 0, 0, 32'h20, 32'h60, 1, 32'h60, 1, 32'h24);
    checkPredict(32'h20, 1'b1, 32'h60);

    // Drive the perf counters into saturation
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 1, 32'h8, 32'h10, 0, 32'h0, 1, 32'h10);

    // Reset asserted while an update is presented
    @(negedge clk);
    e_valid       = 1'b1;
    e_is_branch   = 1'b1;
    e_is_jump     = 1'b0;
    e_taken       = 1'b1;
    e_pc          = 32'h18C;
    e_target      = 32'h1F0;
    e_pred_taken  = 1'b0;
    e_pred_target = 32'h0;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    checkOutput("rst_upd_mispredict", 32'(mispredict), 32'd0);
    checkOutput("rst_upd_redirect", redirect_pc, 32'd0);
    checkOutput("rst_upd_stat_ctl", 32'(stat_ctl), 32'd0);
    checkOutput("rst_upd_stat_mis", 32'(stat_mis), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    expCtl = 0;
    expMis = 0;
    checkPredict(32'h18C, 1'b0, 32'h190);
    checkPredict(32'h20, 1'b0, 32'h24);
    @(posedge clk);
    #1;
    checkOutput("post_rst_mispredict", 32'(mispredict), 32'd0);
    checkOutput("post_rst_stat_ctl", 32'(stat_ctl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no end of run, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
